// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Write-side initiator for the register file. Two result producers share
//   the single write port:
//     - source A (main pipeline writeback): single-cycle, never stalled,
//       always wins the port.
//     - source B (long-latency unit): valid/ready handshake into a small
//       FIFO that drains in cycles where A is idle.
//   A per-register busy scoreboard tracks reserved-but-not-yet-written B
//   destinations for the pipeline's hazard logic.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   a_valid/a_rd/a_data source A write request (accepted unconditionally)
//   b_valid/b_rd/b_data source B write request
//   b_ready             FIFO has a free slot (from registered count only)
//   rsv_valid/rsv_rd    reserve a destination for a future B write
//   busy                scoreboard, bit i = B write to register i pending
//   fifo_count          FIFO occupancy
//   rf_we/rf_rd/rf_data registered register-file write port
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_valid,
    input  logic [ADDR_WIDTH-1:0]         a_rd,
    input  logic [DATA_WIDTH-1:0]         a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [ADDR_WIDTH-1:0]         b_rd,
    input  logic [DATA_WIDTH-1:0]         b_data,
    input  logic                          rsv_valid,
    input  logic [ADDR_WIDTH-1:0]         rsv_rd,
    output logic [2**ADDR_WIDTH-1:0]      busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_rd,
    output logic [DATA_WIDTH-1:0]         rf_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_WIDTH;

    // FIFO storage and control
    logic [ADDR_WIDTH-1:0] r_fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Scoreboard and registered write port
    logic [NREG-1:0]       r_busy;
    logic                  r_rf_we;
    logic [ADDR_WIDTH-1:0] r_rf_rd;
    logic [DATA_WIDTH-1:0] r_rf_data;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [NREG-1:0]       w_busy_nxt;

    // Ready looks only at the registered count, so a pop in this cycle never
    // makes room for a push in the same cycle.
    assign b_ready     = !rst && (r_count < CNT_W'(FIFO_DEPTH));
    assign w_push      = b_valid && b_ready;
    // A owns the port whenever it is valid; B drains only into idle slots.
    assign w_pop       = !a_valid && (r_count != '0);
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Clear on pop first, then apply the reservation, so a new reservation of
    // the register just completed survives. Register 0 is never tracked.
    always_comb begin
        // NOTE: default assignment first so no path through this block leaves
        // w_busy_nxt unassigned, which would infer a latch.
        w_busy_nxt = r_busy;
        if (w_pop && (w_head_rd != '0)) begin
            w_busy_nxt[w_head_rd] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            w_busy_nxt[rsv_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count
    // define which entries are live, and a reset-free array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= b_rd;
            r_fifo_data[r_wr_ptr] <= b_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_busy    <= '0;
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            r_busy <= w_busy_nxt;

            // Writes to register 0 still use their slot but never assert we.
            if (a_valid) begin
                r_rf_we   <= (a_rd != '0);
                r_rf_rd   <= a_rd;
                r_rf_data <= a_data;
            end else if (w_pop) begin
                r_rf_we   <= (w_head_rd != '0);
                r_rf_rd   <= w_head_rd;
                r_rf_data <= w_head_data;
            end else begin
                r_rf_we   <= 1'b0;
            end
        end
    end

    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign rf_we      = r_rf_we;
    assign rf_rd      = r_rf_rd;
    assign rf_data    = r_rf_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Self-checking bench for rf_wb_arbiter. A hand-written vector table
//   covers the basic write paths, short directed sequences cover the
//   multi-cycle corners, and a random phase is compared cycle by cycle
//   against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid;
    logic [AW-1:0] a_rd;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_rd;
    logic [DW-1:0] b_data;
    logic          rsv_valid;
    logic [AW-1:0] rsv_rd;
    logic [31:0]   busy;
    logic [2:0]    fifo_count;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .rsv_valid  (rsv_valid),
        .rsv_rd     (rsv_rd),
        .busy       (busy),
        .fifo_count (fifo_count),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          a_valid;
        logic [AW-1:0] a_rd;
        logic [DW-1:0] a_data;
        logic          b_valid;
        logic [AW-1:0] b_rd;
        logic [DW-1:0] b_data;
        logic          rsv_valid;
        logic [AW-1:0] rsv_rd;
    } in_t;

    typedef struct {
        in_t           in;
        logic          we;
        logic          chk_rd;   // compare rf_rd/rf_data on this row
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            cnt;
        logic          ready;
        logic [31:0]   busy;
    } vec_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    int n_vec = 0;
    int n_err = 0;

    in_t  cur;
    vec_t tbl[$];

    // Reference model state
    ent_t        mq[$];
    logic [31:0] m_busy;
    logic        m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    logic        m_known;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic r, input logic av, input logic [AW-1:0] ard,
                               input logic [DW-1:0] ad, input logic bv, input logic [AW-1:0] brd,
                               input logic [DW-1:0] bd, input logic rv, input logic [AW-1:0] rrd);
        in_t x;
        x.rst = r; x.a_valid = av; x.a_rd = ard; x.a_data = ad;
        x.b_valid = bv; x.b_rd = brd; x.b_data = bd;
        x.rsv_valid = rv; x.rsv_rd = rrd;
        return x;
    endfunction

    function automatic in_t idle();
        return mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endfunction

    task automatic add(input in_t x, input logic we, input logic chk, input logic [AW-1:0] rd,
                       input logic [DW-1:0] data, input int cnt, input logic rdy, input logic [31:0] bz);
        vec_t v;
        v.in = x; v.we = we; v.chk_rd = chk; v.rd = rd; v.data = data;
        v.cnt = cnt; v.ready = rdy; v.busy = bz;
        tbl.push_back(v);
    endtask

    task automatic apply(input in_t x);
        cur       = x;
        rst       = x.rst;
        a_valid   = x.a_valid;
        a_rd      = x.a_rd;
        a_data    = x.a_data;
        b_valid   = x.b_valid;
        b_rd      = x.b_rd;
        b_data    = x.b_data;
        rsv_valid = x.rsv_valid;
        rsv_rd    = x.rsv_rd;
    endtask

    // One clock: advance the model from the applied inputs, take the edge,
    // then compare every DUT output against the model.
    task automatic step();
        logic exp_ready;
        logic do_pop;
        ent_t head;
        #1;
        exp_ready = !cur.rst && (mq.size() < D);
        check("b_ready_pre", 64'(b_ready), 64'(exp_ready));
        if (cur.rst) begin
            mq.delete();
            m_busy  = '0;
            m_we    = 1'b0;
            m_rd    = '0;
            m_data  = '0;
            m_known = 1'b1;
        end else begin
            do_pop = !cur.a_valid && (mq.size() > 0);
            head   = '{rd: '0, data: '0};
            if (do_pop) head = mq.pop_front();
            if (cur.b_valid && exp_ready) mq.push_back('{rd: cur.b_rd, data: cur.b_data});
            if (do_pop && head.rd != 0) m_busy[head.rd] = 1'b0;
            if (cur.rsv_valid && cur.rsv_rd != 0) m_busy[cur.rsv_rd] = 1'b1;
            if (cur.a_valid) begin
                m_we = (cur.a_rd != 0); m_rd = cur.a_rd; m_data = cur.a_data; m_known = m_we;
            end else if (do_pop) begin
                m_we = (head.rd != 0); m_rd = head.rd; m_data = head.data; m_known = m_we;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("rf_we", 64'(rf_we), 64'(m_we));
        if (m_known) begin
            check("rf_rd", 64'(rf_rd), 64'(m_rd));
            check("rf_data", 64'(rf_data), 64'(m_data));
        end
        check("fifo_count", 64'(fifo_count), 64'(mq.size()));
        check("busy", 64'(busy), 64'(m_busy));
        check("b_ready", 64'(b_ready), 64'(!cur.rst && (mq.size() < D)));
    endtask

    initial begin
        apply(mk(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0));
        m_busy = '0; m_we = 1'b0; m_rd = '0; m_data = '0; m_known = 1'b0;

        // ---------------- table: {inputs, expected outputs after the edge}
        add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0),                   0, 1, 0,  0,            0, 0, 32'h0);   // reset
        add(mk(0, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0),       1, 1, 5,  32'h1234_5678, 0, 1, 32'h0);  // A write
        add(idle(),                                          0, 1, 5,  32'h1234_5678, 0, 1, 32'h0);  // hold
        add(mk(0, 0, 0, 0, 0, 0, 0, 1, 9),                   0, 0, 0,  0,            0, 1, 32'h200); // reserve 9
        add(mk(0, 0, 0, 0, 1, 9, 32'hDEAD_BEEF, 0, 0),       0, 0, 0,  0,            1, 1, 32'h200); // push B
        add(idle(),                                          1, 1, 9,  32'hDEAD_BEEF, 0, 1, 32'h0);  // pop B
        add(idle(),                                          0, 1, 9,  32'hDEAD_BEEF, 0, 1, 32'h0);
        add(mk(0, 0, 0, 0, 1, 10, 32'hA0, 0, 0),             0, 0, 0,  0,            1, 1, 32'h0);
        add(mk(0, 1, 1, 32'h11, 1, 11, 32'hB0, 0, 0),        1, 1, 1,  32'h11,       2, 1, 32'h0);   // A wins
        add(mk(0, 1, 2, 32'h22, 0, 0, 0, 0, 0),              1, 1, 2,  32'h22,       2, 1, 32'h0);
        add(mk(0, 1, 3, 32'h33, 0, 0, 0, 0, 0),              1, 1, 3,  32'h33,       2, 1, 32'h0);
        add(idle(),                                          1, 1, 10, 32'hA0,       1, 1, 32'h0);   // B drains
        add(idle(),                                          1, 1, 11, 32'hB0,       0, 1, 32'h0);
        add(mk(0, 0, 0, 0, 1, 0, 32'h55, 0, 0),              0, 0, 0,  0,            1, 1, 32'h0);   // B to r0
        add(idle(),                                          0, 0, 0,  0,            0, 1, 32'h0);   // popped, no we

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].in);
            step();
            check($sformatf("tbl%0d_we", i), 64'(rf_we), 64'(tbl[i].we));
            if (tbl[i].chk_rd) begin
                check($sformatf("tbl%0d_rd", i), 64'(rf_rd), 64'(tbl[i].rd));
                check($sformatf("tbl%0d_data", i), 64'(rf_data), 64'(tbl[i].data));
            end
            check($sformatf("tbl%0d_cnt", i), 64'(fifo_count), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d_ready", i), 64'(b_ready), 64'(tbl[i].ready));
            check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
        end

        // ---------------- simultaneous set and clear of the same register
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 7));                step();
        apply(mk(0, 0, 0, 0, 1, 7, 32'h7777, 0, 0));         step();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 7));                step();
        check("setclr_busy7", 64'(busy[7]), 64'd1);
        check("setclr_rd", 64'(rf_rd), 64'd7);
        apply(idle());                                       step();

        // ---------------- full FIFO under sustained A, then drain with wrap
        for (int i = 0; i < 5; i++) begin
            apply(mk(0, 1, AW'(i + 1), $urandom, 1, AW'(i + 12), $urandom, 0, 0));
            step();
        end
        check("full_cnt", 64'(fifo_count), 64'd4);
        check("full_ready", 64'(b_ready), 64'd0);
        for (int i = 0; i < 7; i++) begin
            apply(mk(0, 0, 0, 0, (i < 3) ? 1'b1 : 1'b0, AW'(20 + i), $urandom, 0, 0));
            step();
        end
        check("drain_cnt", 64'(fifo_count), 64'd0);

        // ---------------- reset mid-operation
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 4));                step();
        for (int i = 0; i < 3; i++) begin
            apply(mk(0, 1, 1, $urandom, 1, AW'(4 + i), $urandom, 0, 0));
            step();
        end
        check("pre_rst_cnt", 64'(fifo_count), 64'd3);
        check("pre_rst_busy4", 64'(busy[4]), 64'd1);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));                step();
        check("rst_cnt", 64'(fifo_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_ready", 64'(b_ready), 64'd0);
        apply(idle());
        #1;
        check("post_rst_ready", 64'(b_ready), 64'd1);
        step();

        // ---------------- randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_t x;
            x.rst       = ($urandom_range(0, 199) == 0);
            x.a_valid   = ($urandom_range(0, 9) < 4);
            x.a_rd      = AW'($urandom_range(0, 7));
            x.a_data    = $urandom;
            x.b_valid   = ($urandom_range(0, 9) < 5);
            x.b_rd      = AW'($urandom_range(0, 7));
            x.b_data    = $urandom;
            x.rsv_valid = ($urandom_range(0, 9) < 3);
            x.rsv_rd    = AW'($urandom_range(0, 7));
            apply(x);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-side initiator for the register file: drives its single write port (we, rd, data_in) from two result producers.
- Source A is the main pipeline writeback: single-cycle, no backpressure, always wins.
- Source B is a long-latency unit (load/mul/div) using valid/ready. Its writes are buffered in a small FIFO and drain in idle write slots.
- Keeps a per-register busy scoreboard for B-destined writes, used by hazard/stall logic.

Parameters:
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register address width; register count = 2**ADDR_WIDTH.
- FIFO_DEPTH, 4, source-B buffer entries; power of two, at least 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- a_valid  input  1  source A write request, accepted unconditionally.
- a_rd  input  ADDR_WIDTH  source A destination.
- a_data  input  DATA_WIDTH  source A data.
- b_valid  input  1  source B write request.
- b_ready  output  1  FIFO can accept a source B write.
- b_rd  input  ADDR_WIDTH  source B destination.
- b_data  input  DATA_WIDTH  source B data.
- rsv_valid  input  1  reserve a destination for a future B write.
- rsv_rd  input  ADDR_WIDTH  register to reserve.
- busy  output  2**ADDR_WIDTH  scoreboard; bit i set means a B write to register i is pending.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- rf_we  output  1  register-file write enable.
- rf_rd  output  ADDR_WIDTH  register-file write address.
- rf_data  output  DATA_WIDTH  register-file write data.

Behaviour:
- Reset (rst high at an edge):
  - rf_we=0, rf_rd=0, rf_data=0.
  - FIFO emptied: fifo_count=0, pointers=0.
  - busy=0.
  - b_ready=0 while rst is high.
- b_ready = !rst && (fifo_count < FIFO_DEPTH). It depends only on the registered count, so a pop in the same cycle does not free a slot for a push.
- Push: b_valid && b_ready at an edge writes {b_rd, b_data} at the tail.
- Arbitration per cycle, priority A over B:
  - a_valid: next rf_we=1, rf_rd=a_rd, rf_data=a_data. The FIFO does not pop.
  - else FIFO non-empty: pop the head; next rf_we=1 with the head's rd and data.
  - else: next rf_we=0. rf_rd and rf_data hold their previous values.
- Latency:
  - A accepted at edge t: rf_we high in cycle t+1 (registered, one cycle).
  - B pushed at edge t into an empty FIFO with no A traffic: popped at edge t+1, rf_we high in cycle t+2. There is no FIFO bypass.
- rd==0 writes (either source):
  - Still consume the slot and pop, but drive rf_we=0.
  - The scoreboard is not touched.
- Push and pop in the same cycle: both occur; fifo_count is unchanged.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
- Scoreboard:
  - Set: rsv_valid && rsv_rd!=0 sets busy[rsv_rd] at the edge.
  - Clear: the B pop edge clears busy[head rd].
  - Same register set and cleared at the same edge: set wins (a new reservation follows the completed one).
  - busy[0] is constant 0.
  - A writes never modify busy.
- No ordering check between A and B to the same rd. Ordering is the pipeline's responsibility via busy.
- Sustained A traffic starves B. The FIFO fills and b_ready drops; there is no loss and no overflow.
- Reset mid-operation:
  - Pending FIFO entries are discarded and busy is cleared.
  - rf_we is 0 in the cycle after the reset edge.

Test Plan:
- A only: a_valid=1, a_rd=5, a_data=0x1234_5678 at edge t -> cycle t+1 rf_we=1, rf_rd=5, rf_data=0x12345678; cycle t+2 rf_we=0.
- B with scoreboard: rsv_rd=9, then b_rd=9, b_data=0xDEAD_BEEF pushed at t, A idle -> busy[9]=1 until edge t+1; rf_we=1, rf_rd=9 in cycle t+2.
- Priority and starvation: FIFO holds 2 B entries; a_valid held for 3 cycles (rd 1,2,3) -> three A writes first, then both B entries in push order; fifo_count goes 2->2->2->1->0.
- Full: a_valid held high, push 4 B writes -> fifo_count=4, b_ready=0, a 5th b_valid is not accepted. Drop a_valid -> 4 pops in order; the wrap is exercised by pushing 2 more during the drain.
- rd==0 and simultaneous set/clear:
  - B write to rd=0 -> popped, rf_we stays 0, busy unchanged.
  - Pop of rd=7 at the same edge as rsv_rd=7 -> busy[7] remains 1.
- Reset mid-operation: FIFO holds 3 entries, busy[4]=1, rst high for 1 cycle -> fifo_count=0, busy=0, rf_we=0, b_ready=0 during reset and 1 after.
